// File: rtl/fft_pkg.sv
// Shared types and arithmetic for the iterative radix-2 FFT: FSM states,
// complex add/sub/multiply, bit reversal and the twiddle ROM generator.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } fft_state_t;

    typedef struct packed {
        longint re;
        longint im;
    } cplx_t;

    localparam int  TW_SLOTS = 32;
    localparam int  TW_BITS  = 64;
    localparam real PI       = 3.14159265358979323846;

    function automatic cplx_t c_add(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re + y.re;
        r.im = x.im + y.im;
        return r;
    endfunction

    function automatic cplx_t c_sub(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re - y.re;
        r.im = x.im - y.im;
        return r;
    endfunction

    // Full-precision products, then arithmetic shift drops the Q1.frac scaling (floor).
    function automatic cplx_t c_mul(input cplx_t x, input cplx_t w, input int frac);
        cplx_t r;
        r.re = (x.re * w.re - x.im * w.im) >>> frac;
        r.im = (x.re * w.im + x.im * w.re) >>> frac;
        return r;
    endfunction

    function automatic logic [5:0] bitrev(input logic [5:0] v, input int bits);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < bits) begin
                r[bits - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

    // Slot k holds {re[31:0], im[31:0]} of exp(-j*2*pi*k/n) in Q1.(dw/2-1).
    function automatic logic [TW_SLOTS*TW_BITS-1:0] twiddle_table(input int n, input int dw);
        logic [TW_SLOTS*TW_BITS-1:0] tab;
        longint one;
        longint re;
        longint im;
        real    ang;
        tab = '0;
        one = 64'sd1 << (dw / 2 - 1);
        for (int k = 0; k < TW_SLOTS; k++) begin
            if (k < n / 2) begin
                ang = 2.0 * PI * real'(k) / real'(n);
                re  = longint'($cos(ang) * real'(one));
                im  = longint'(-$sin(ang) * real'(one));
                // +1.0 is not representable in Q1.x, clamp to the largest positive code
                if (re >= one) re = one - 64'sd1;
                if (im >= one) im = one - 64'sd1;
                tab[k*TW_BITS +: 32]      = im[31:0];
                tab[k*TW_BITS + 32 +: 32] = re[31:0];
            end
        end
        return tab;
    endfunction

endpackage

// File: rtl/fft_radix2_iter_butterfly.sv
// Combinational radix-2 DIT butterfly: a' = a + W*b, b' = a - W*b, with
// optional divide-by-two scaling and a multiplier bypass for W^0.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int DW    = 32,
    parameter int SCALE = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] w,
    input  logic          bypass,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out
);

    localparam int HW = DW / 2;

    cplx_t a_s;
    cplx_t b_s;
    cplx_t w_s;
    cplx_t t_s;
    cplx_t sum_s;
    cplx_t dif_s;

    // Widen operands, form W*b (or b itself for W^0) and the two sums.
    always_comb begin
        a_s.re = longint'($signed(a[DW-1:HW]));
        a_s.im = longint'($signed(a[HW-1:0]));
        b_s.re = longint'($signed(b[DW-1:HW]));
        b_s.im = longint'($signed(b[HW-1:0]));
        w_s.re = longint'($signed(w[DW-1:HW]));
        w_s.im = longint'($signed(w[HW-1:0]));
        if (bypass) begin
            t_s = b_s;
        end else begin
            t_s = c_mul(b_s, w_s, HW - 1);
        end
        sum_s = c_add(a_s, t_s);
        dif_s = c_sub(a_s, t_s);
    end

    // Bits [HW:1] of the sum are the (HW+1)-bit result shifted right by one.
    always_comb begin
        if (SCALE != 0) begin
            a_out = {HW'(sum_s.re >>> 1), HW'(sum_s.im >>> 1)};
            b_out = {HW'(dif_s.re >>> 1), HW'(dif_s.im >>> 1)};
        end else begin
            a_out = {HW'(sum_s.re), HW'(sum_s.im)};
            b_out = {HW'(dif_s.re), HW'(dif_s.im)};
        end
    end

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per
// cycle over log2(N) stages, natural-order unload with ready/valid backpressure.
module fft_radix2_iter
    import fft_pkg::*;
#(
    parameter int N_POINTS = 4,
    parameter int DW       = 32,
    parameter int SCALE    = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [DW-1:0]               in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DW-1:0]               out_data,
    output logic [$clog2(N_POINTS)-1:0] out_index,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int LOGN = $clog2(N_POINTS);
    localparam int HW   = DW / 2;
    localparam int NB   = N_POINTS / 2;
    localparam logic [TW_SLOTS*TW_BITS-1:0] TW = twiddle_table(N_POINTS, DW);

    if (N_POINTS < 4 || N_POINTS > 64 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_points
        $error("fft_radix2_iter: N_POINTS must be a power of two in 4..64");
    end
    if (DW < 4 || DW > 32 || (DW % 2) != 0) begin : g_bad_width
        $error("fft_radix2_iter: DW must be even and in 4..32");
    end

    fft_state_t      state_r;
    fft_state_t      state_s;
    logic [LOGN-1:0] ld_cnt_r;
    logic [2:0]      stage_r;
    logic [LOGN-2:0] bf_r;
    logic [DW-1:0]   mem_r [N_POINTS];

    logic            load_xfer_s;
    logic            unload_xfer_s;
    logic            last_bin_s;
    logic            stage_end_s;
    logic            last_bf_s;
    logic [LOGN-1:0] bf_ext_s;
    logic [LOGN-1:0] mask_s;
    logic [LOGN-1:0] top_s;
    logic [LOGN-1:0] bot_s;
    logic [LOGN-1:0] tw_idx_s;
    logic [DW-1:0]   w_s;
    logic [DW-1:0]   a_new_s;
    logic [DW-1:0]   b_new_s;

    // Handshake and sequencing conditions.
    always_comb begin
        load_xfer_s   = in_ready & in_valid;
        unload_xfer_s = out_valid & out_ready;
        last_bin_s    = (out_index == LOGN'(N_POINTS - 1));
        stage_end_s   = (bf_r == (LOGN-1)'(NB - 1));
        last_bf_s     = stage_end_s && (stage_r == 3'(LOGN - 1));
    end

    // Butterfly j of stage s pairs (top, top + 2^s) with twiddle index (j mod 2^s) * N/2^(s+1).
    always_comb begin
        bf_ext_s = LOGN'(bf_r);
        mask_s   = (LOGN'(1'b1) << stage_r) - LOGN'(1'b1);
        top_s    = ((bf_ext_s >> stage_r) << (stage_r + 3'd1)) | (bf_ext_s & mask_s);
        bot_s    = top_s | (LOGN'(1'b1) << stage_r);
        tw_idx_s = (bf_ext_s & mask_s) << (3'(LOGN - 1) - stage_r);
        w_s      = {TW[int'(tw_idx_s)*TW_BITS + 32 +: HW], TW[int'(tw_idx_s)*TW_BITS +: HW]};
    end

    fft_butterfly #(
        .DW    (DW),
        .SCALE (SCALE)
    ) u_butterfly (
        .a      (mem_r[top_s]),
        .b      (mem_r[bot_s]),
        .w      (w_s),
        .bypass (tw_idx_s == LOGN'(1'b0)),
        .a_out  (a_new_s),
        .b_out  (b_new_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_LOAD;
                else       state_s = S_IDLE;
            end
            S_LOAD: begin
                if (load_xfer_s && ld_cnt_r == LOGN'(N_POINTS - 1)) state_s = S_COMPUTE;
                else                                                state_s = S_LOAD;
            end
            S_COMPUTE: begin
                if (last_bf_s) state_s = S_UNLOAD;
                else           state_s = S_COMPUTE;
            end
            S_UNLOAD: begin
                if (unload_xfer_s && last_bin_s) state_s = S_IDLE;
                else                             state_s = S_UNLOAD;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            ld_cnt_r  <= '0;
            stage_r   <= 3'd0;
            bf_r      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            in_ready  <= (state_s == S_LOAD);
            out_valid <= (state_s == S_UNLOAD);
            busy      <= (state_s != S_IDLE);
            done      <= unload_xfer_s && last_bin_s;
            if (load_xfer_s) ld_cnt_r <= ld_cnt_r + LOGN'(1'b1);
            if (state_r == S_COMPUTE) begin
                if (stage_end_s) begin
                    bf_r    <= '0;
                    stage_r <= last_bf_s ? 3'd0 : stage_r + 3'd1;
                end else begin
                    bf_r    <= bf_r + (LOGN-1)'(1'b1);
                end
            end
            // The final butterfly never writes bin 0, so it is already settled here.
            if (state_r == S_COMPUTE && state_s == S_UNLOAD) begin
                out_index <= '0;
                out_data  <= mem_r[0];
            end else if (unload_xfer_s && !last_bin_s) begin
                out_index <= out_index + LOGN'(1'b1);
                out_data  <= mem_r[out_index + LOGN'(1'b1)];
            end else if (unload_xfer_s) begin
                out_index <= '0;
            end
        end
    end

    // Sample storage: deliberately not reset, every LOAD rewrites all of it.
    always_ff @(posedge clk) begin
        if (reset && load_xfer_s) begin
            mem_r[LOGN'(bitrev(6'(ld_cnt_r), LOGN))] <= in_data;
        end else if (reset && state_r == S_COMPUTE) begin
            mem_r[top_s] <= a_new_s;
            mem_r[bot_s] <= b_new_s;
        end
    end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Self-checking bench: three configurations (N=4, N=8, N=8 scaled) against a
// loop-level fixed-point FFT reference plus directed corner cases.
module tb_fft_radix2_iter;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        start;
    logic [2:0]        in_valid;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [2:0]        busy;
    logic [2:0]        done;
    logic [2:0][31:0]  in_data;
    logic [2:0][31:0]  out_data;
    logic [1:0]        oidx4;
    logic [2:0]        oidx8;
    logic [2:0]        oidx8s;
    logic [5:0]        oidx [3];

    logic signed [15:0] stim_re [64];
    logic signed [15:0] stim_im [64];
    logic [31:0]        exp_bin [64];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        oidx[0] = {4'd0, oidx4};
        oidx[1] = {3'd0, oidx8};
        oidx[2] = {3'd0, oidx8s};
    end

    fft_radix2_iter #(.N_POINTS(4), .DW(32), .SCALE(0)) u_dut4 (
        .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_index(oidx4), .out_ready(out_ready[0]),
        .busy(busy[0]), .done(done[0]));

    fft_radix2_iter #(.N_POINTS(8), .DW(32), .SCALE(0)) u_dut8 (
        .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_index(oidx8), .out_ready(out_ready[1]),
        .busy(busy[1]), .done(done[1]));

    fft_radix2_iter #(.N_POINTS(8), .DW(32), .SCALE(1)) u_dut8s (
        .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid[2]),
        .in_data(in_data[2]), .in_ready(in_ready[2]), .out_valid(out_valid[2]),
        .out_data(out_data[2]), .out_index(oidx8s), .out_ready(out_ready[2]),
        .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cx(input int re, input int im);
        logic [15:0] r16;
        logic [15:0] i16;
        r16 = 16'(re);
        i16 = 16'(im);
        return {r16, i16};
    endfunction

    function automatic longint fit16(input longint v, input bit scale);
        logic signed [15:0] t;
        t = scale ? 16'(v >>> 1) : 16'(v);
        return longint'(t);
    endfunction

    // Reference: textbook in-place DIT over groups, quantised as the block defines.
    task automatic model(input int n, input bit scale);
        longint xr [64];
        longint xi [64];
        longint tr, ti, wr, wi, sr, si, dr, di;
        int     lg, half, kk, ia, ib, r;
        real    ang;
        lg = $clog2(n);
        for (int k = 0; k < n; k++) begin
            r = 0;
            for (int bt = 0; bt < lg; bt++) r = (r << 1) | ((k >> bt) & 1);
            xr[r] = longint'(stim_re[k]);
            xi[r] = longint'(stim_im[k]);
        end
        for (int s = 0; s < lg; s++) begin
            half = 1 << s;
            for (int g = 0; g < n; g += 2 * half) begin
                for (int p = 0; p < half; p++) begin
                    kk = p * (n / (2 * half));
                    ia = g + p;
                    ib = ia + half;
                    if (kk == 0) begin
                        tr = xr[ib];
                        ti = xi[ib];
                    end else begin
                        ang = 2.0 * 3.14159265358979323846 * real'(kk) / real'(n);
                        wr  = longint'($floor($cos(ang) * 32768.0 + 0.5));
                        wi  = longint'($floor(-$sin(ang) * 32768.0 + 0.5));
                        if (wr > 32767) wr = 32767;
                        if (wi > 32767) wi = 32767;
                        tr = (xr[ib] * wr - xi[ib] * wi) >>> 15;
                        ti = (xr[ib] * wi + xi[ib] * wr) >>> 15;
                    end
                    sr = xr[ia] + tr;  si = xi[ia] + ti;
                    dr = xr[ia] - tr;  di = xi[ia] - ti;
                    xr[ia] = fit16(sr, scale);  xi[ia] = fit16(si, scale);
                    xr[ib] = fit16(dr, scale);  xi[ib] = fit16(di, scale);
                end
            end
        end
        for (int i = 0; i < n; i++) exp_bin[i] = cx(int'(xr[i]), int'(xi[i]));
    endtask

    task automatic check_idle(input int u, input string tag);
        check($sformatf("%s_in_ready%0d", tag, u), in_ready[u], 0);
        check($sformatf("%s_out_valid%0d", tag, u), out_valid[u], 0);
        check($sformatf("%s_out_data%0d", tag, u), out_data[u], 0);
        check($sformatf("%s_out_index%0d", tag, u), oidx[u], 0);
        check($sformatf("%s_busy%0d", tag, u), busy[u], 0);
        check($sformatf("%s_done%0d", tag, u), done[u], 0);
    endtask

    task automatic load_frame(input int u, input int n, input bit gaps);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        check("load_in_ready", in_ready[u], 1);
        check("load_busy", busy[u], 1);
        check("load_done_low", done[u], 0);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid[u] = 1'b0;
                in_data[u]  = $urandom;
                @(negedge clk);
            end
            in_valid[u] = 1'b1;
            in_data[u]  = {stim_re[k], stim_im[k]};
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
    endtask

    task automatic wait_compute(input int u, input int n, input bit disturb);
        int cnt;
        cnt = 0;
        check("compute_in_ready", in_ready[u], 0);
        while (!out_valid[u] && cnt < 300) begin
            if (disturb) begin
                start[u]    = (cnt == 1);
                in_valid[u] = (cnt == 2);
                in_data[u]  = $urandom;
            end
            cnt++;
            @(negedge clk);
        end
        start[u]    = 1'b0;
        in_valid[u] = 1'b0;
        check("compute_cycles", cnt, (n / 2) * $clog2(n));
    endtask

    task automatic unload(input int u, input int n, input int stall_bin, input int stall_len,
                          input bit rnd, input bit disturb);
        logic [31:0] got;
        int          stall;
        for (int i = 0; i < n; i++) begin
            check("out_valid", out_valid[u], 1);
            check("out_index", oidx[u], i);
            got   = out_data[u];
            stall = (i == stall_bin) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            out_ready[u] = 1'b0;
            for (int s = 0; s < stall; s++) begin
                start[u] = disturb;
                @(negedge clk);
                check("hold_data", out_data[u], got);
                check("hold_index", oidx[u], i);
                check("hold_valid", out_valid[u], 1);
            end
            start[u]     = 1'b0;
            out_ready[u] = 1'b1;
            @(negedge clk);
            out_ready[u] = 1'b0;
            check($sformatf("bin%0d_n%0d_u%0d", i, n, u), got, exp_bin[i]);
        end
        check("done_pulse", done[u], 1);
        check("out_valid_end", out_valid[u], 0);
        check("busy_end", busy[u], 0);
    endtask

    task automatic run_frame(input int u, input int n, input bit rnd, input int stall_bin,
                             input int stall_len, input bit disturb);
        load_frame(u, n, rnd);
        wait_compute(u, n, disturb);
        unload(u, n, stall_bin, stall_len, rnd, disturb);
    endtask

    task automatic set_ramp4();
        for (int k = 0; k < 4; k++) begin
            stim_re[k] = 16'(k);
            stim_im[k] = 16'sd0;
        end
        exp_bin[0] = cx(6, 0);
        exp_bin[1] = cx(-2, 2);
        exp_bin[2] = cx(-2, 0);
        exp_bin[3] = cx(-2, -2);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        reset     = 1'b0;
        start     = '0;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) check_idle(u, "rst");
        reset = 1'b1;
        @(negedge clk);

        set_ramp4();
        run_frame(0, 4, 1'b0, -1, 0, 1'b0);
        set_ramp4();
        run_frame(0, 4, 1'b0, 1, 3, 1'b0);
        set_ramp4();
        run_frame(0, 4, 1'b0, 1, 2, 1'b1);

        // Abort a transform mid-COMPUTE, then repeat the ramp from scratch.
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            stim_re[k] = v[31:16];
            stim_im[k] = v[15:0];
        end
        load_frame(0, 4, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", busy[0], 1);
        reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) check_idle(u, "midreset");
        reset = 1'b1;
        @(negedge clk);
        set_ramp4();
        run_frame(0, 4, 1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            stim_re[k] = 16'sd8;
            stim_im[k] = 16'sd0;
            exp_bin[k] = (k == 0) ? cx(64, 0) : cx(0, 0);
        end
        run_frame(1, 8, 1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            stim_re[k] = (k == 0) ? 16'sd100 : 16'sd0;
            stim_im[k] = 16'sd0;
            exp_bin[k] = cx(12, 0);
        end
        run_frame(2, 8, 1'b0, -1, 0, 1'b0);

        // Back-to-back random frames: the second start lands in the done cycle.
        for (int it = 0; it < 6; it++) begin
            for (int u = 0; u < 3; u++) begin
                n = (u == 0) ? 4 : 8;
                for (int rep = 0; rep < 2; rep++) begin
                    for (int k = 0; k < n; k++) begin
                        v = $urandom;
                        if (it % 2 == 0) begin
                            stim_re[k] = v[31:16];
                            stim_im[k] = v[15:0];
                        end else begin
                            stim_re[k] = {{7{v[24]}}, v[24:16]};
                            stim_im[k] = {{7{v[8]}}, v[8:0]};
                        end
                    end
                    model(n, u == 2);
                    run_frame(u, n, 1'b1, -1, 0, 1'b0);
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_radix2_iter.md
FFT_RADIX2_ITER -- requirements
Module: fft_radix2_iter

Interface
REQ-001 Parameter N_POINTS, default 4, transform length; power of two, 4..64; other values SHALL fail elaboration.
REQ-002 Parameter DW, default 32, complex word width; real = [DW-1:DW/2], imag = [DW/2-1:0], both signed two's complement.
REQ-003 Parameter SCALE, default 0; 0 = no scaling (wrap on overflow), 1 = divide by 2 per stage.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 start  input  1  begin a transform; sampled only in IDLE.
REQ-008 in_valid  input  1  sample present on in_data.
REQ-009 in_data  input  DW  complex time sample, natural order.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 out_valid  output  1  out_data holds a frequency bin.
REQ-012 out_data  output  DW  complex bin X[out_index].
REQ-013 out_index  output  log2(N_POINTS)  bin number of out_data.
REQ-014 out_ready  input  1  consumer accepts out_data this cycle.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse, last bin transferred.

Function
REQ-017 FSM states IDLE, LOAD, COMPUTE, UNLOAD; IDLE->LOAD when start=1; start SHALL be ignored in all other states.
REQ-018 LOAD: in_ready=1; transfer when in_valid&in_ready; sample k SHALL be written to storage address bitreverse(k); after the N_POINTS-th transfer -> COMPUTE next cycle.
REQ-019 COMPUTE: radix-2 decimation-in-time, in place on a register array, exactly one butterfly per cycle, log2(N) stages of N/2 butterflies; COMPUTE SHALL last exactly (N/2)*log2(N) cycles (4 for N=4), then -> UNLOAD.
REQ-020 Butterfly: t = W*b; a' = a+t, b' = a-t; W = exp(-j*2*pi*k/N).
REQ-021 Twiddles Q1.(DW/2-1); cos values of +1 saturate to max positive; W^0 SHALL bypass the multiplier (t = b exactly).
REQ-022 Complex multiply: full-precision products, sum, then arithmetic shift right by DW/2-1 (truncation toward minus infinity).
REQ-023 SCALE=0: a', b' truncated to DW/2 bits per component (two's-complement wrap). SCALE=1: a', b' computed at DW/2+1 bits then arithmetic shift right 1.
REQ-024 UNLOAD: out_valid=1, out_data = bin out_index, out_index starts at 0, natural order; index advances only on out_valid&out_ready.
REQ-025 out_valid=1 with out_ready=0: out_data and out_index SHALL hold stable.
REQ-026 Transfer of bin N-1: done=1 for the following cycle, out_valid=0, state -> IDLE; start in that same IDLE cycle is accepted.
REQ-027 in_ready=0 outside LOAD; in_valid outside LOAD ignored, storage unchanged.

Reset
REQ-028 reset=0 at a rising edge, in any state (including mid-LOAD/COMPUTE/UNLOAD): state -> IDLE, all counters 0, in_ready=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
REQ-029 Storage array contents SHALL NOT be cleared by reset; every transform fully overwrites them in LOAD.

Structure
REQ-030 Package fft_pkg SHALL hold the state enum, complex add/sub/multiply functions, and a constant function producing the twiddle table for N_POINTS and DW.
REQ-031 One sub-module fft_butterfly: combinational, inputs a, b, W, bypass flag, SCALE; outputs a', b'.
REQ-032 Address/twiddle-index generation and the FSM SHALL stay in fft_radix2_iter.

Verification
REQ-033 N=4, DW=32, SCALE=0, in = 0,1,2,3 (real) -> X0=6+0j, X1=-2+2j, X2=-2+0j, X3=-2-2j; done after bin 3.
REQ-034 N=8, SCALE=0, all inputs 8+0j -> X0=64+0j, X1..X7=0+0j; COMPUTE exactly 12 cycles.
REQ-035 N=8, SCALE=1, impulse x0=100+0j, others 0 -> all eight bins 12+0j.
REQ-036 N=4 UNLOAD with out_ready low 3 cycles at bin 1 -> out_data=-2+2j, out_index=1 held stable all 3 cycles, no bin skipped.
REQ-037 reset=0 during COMPUTE, then new start with REQ-033 data -> all outputs 0 in reset cycle, REQ-033 results reproduced exactly.
REQ-038 start pulsed during COMPUTE and UNLOAD, in_valid pulsed in COMPUTE -> no state change, results equal REQ-033.
